mac_accum_requant: RTL and testbench

- Downstream stage of the PE_MAC array.
- Consumes the signed 16-bit PE partial products/sums one per cycle over a valid/ready stream.
- Accumulates a configurable number of them per output pixel, then requantizes to signed int8 with round-half-up, arithmetic shift and saturation.
- Int8 results are handed to the activation/output buffer over valid/ready.

---
 rtl/mac_accum_requant_pkg.sv | 10 +
 rtl/mac_accum_requant_if.sv | 15 +
 rtl/mac_accum_requant_requant_rs.sv | 24 ++
 rtl/mac_accum_requant.sv | 94 +++++++++
 tb/tb_mac_accum_requant.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mac_accum_requant_pkg.sv
// mac_accum_requant_pkg: shared state encoding, widths and int8 bounds
package mac_accum_requant_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, HOLD} acc_state_t;
  localparam int DW_IN = 16;
  localparam int ACC_W = 24;
  localparam int DW_OUT = 8;
  localparam int CNT_W = 8;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
endpackage

// File: rtl/mac_accum_requant_if.sv
// mac_accum_requant_if: partial-sum input stream and int8 result stream
interface mac_accum_requant_if #(
  parameter int DW_IN = mac_accum_requant_pkg::DW_IN,
  parameter int DW_OUT = mac_accum_requant_pkg::DW_OUT
);
  logic in_valid;
  logic in_ready;
  logic signed [DW_IN-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [DW_OUT-1:0] out_data;
  logic out_last;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/mac_accum_requant_requant_rs.sv
// requant_rs: round-half-up arithmetic right shift with int8 saturation
module requant_rs #(
  parameter int ACC_W = mac_accum_requant_pkg::ACC_W,
  parameter int DW_OUT = mac_accum_requant_pkg::DW_OUT
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic [4:0]               shift_i,
  output logic signed [DW_OUT-1:0] q_o,
  output logic                     sat_o
);
  import mac_accum_requant_pkg::*;
  logic signed [ACC_W:0] rnd, sum, r;
  logic hi, lo;
  // the rounding add is one bit wider than the accumulator so it cannot wrap
  always_comb begin
    rnd = (ACC_W+1)'(1) << (shift_i - 5'd1);
    sum = $signed({acc_i[ACC_W-1], acc_i}) + rnd;
    r = shift_i == 5'd0 ? $signed({acc_i[ACC_W-1], acc_i}) : sum >>> shift_i;
    hi = r > INT8_MAX;
    lo = r < INT8_MIN;
    q_o = hi ? DW_OUT'(INT8_MAX) : lo ? DW_OUT'(INT8_MIN) : r[DW_OUT-1:0];
    sat_o = hi | lo;
  end
endmodule

// File: rtl/mac_accum_requant.sv
// mac_accum_requant: accumulate partial sums per pixel and requantize to int8
module mac_accum_requant #(
  parameter int DW_IN = mac_accum_requant_pkg::DW_IN,
  parameter int ACC_W = mac_accum_requant_pkg::ACC_W,
  parameter int DW_OUT = mac_accum_requant_pkg::DW_OUT,
  parameter int CNT_W = mac_accum_requant_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_num_out,
  input  logic [4:0]       cfg_shift,
  mac_accum_requant_if.slave s,
  output logic             busy,
  output logic             done,
  output logic             sat_flag
);
  import mac_accum_requant_pkg::*;
  acc_state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q, out_cnt_q, len_q, num_q;
  logic [4:0] shift_q;
  logic signed [DW_OUT-1:0] out_data_q, rq;
  logic out_last_q, done_q, sat_q, rq_sat;
  logic [ACC_W:0] sum;
  logic ovf, hs_in, hs_out, last_in;
  assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-DW_IN){s.in_data[DW_IN-1]}}, s.in_data};
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign hs_in = s.in_valid & s.in_ready;
  assign hs_out = (state_q == HOLD) & s.out_ready;
  assign last_in = cnt_q == len_q - CNT_W'(1);
  assign s.in_ready = state_q == ACCUM;
  assign s.out_valid = state_q == HOLD;
  assign s.out_data = out_data_q;
  assign s.out_last = out_last_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign sat_flag = sat_q;
  requant_rs #(.ACC_W(ACC_W), .DW_OUT(DW_OUT)) u_rs (.acc_i(acc_q), .shift_i(shift_q), .q_o(rq), .sat_o(rq_sat));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: start, collect len sums, one round cycle, hold until taken
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = cfg_start ? ACCUM : IDLE;
    if (state_q == ACCUM) state_d = hs_in && last_in ? ROUND : ACCUM;
    if (state_q == ROUND) state_d = HOLD;
    if (state_q == HOLD) state_d = !s.out_ready ? HOLD : out_last_q ? IDLE : ACCUM;
  end
  // datapath: config latch, saturating accumulate, result register, counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      out_cnt_q <= '0;
      len_q <= '0;
      num_q <= '0;
      shift_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && cfg_start) begin
        len_q <= cfg_len == '0 ? CNT_W'(1) : cfg_len;
        num_q <= cfg_num_out == '0 ? CNT_W'(1) : cfg_num_out;
        shift_q <= cfg_shift;
        acc_q <= '0;
        cnt_q <= '0;
        out_cnt_q <= '0;
        sat_q <= 1'b0;
      end
      if (hs_in) begin
        acc_q <= !ovf ? sum[ACC_W-1:0] : sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        cnt_q <= cnt_q + CNT_W'(1);
        if (ovf) sat_q <= 1'b1;
      end
      if (state_q == ROUND) begin
        out_data_q <= rq;
        out_last_q <= out_cnt_q == num_q - CNT_W'(1);
        if (rq_sat) sat_q <= 1'b1;
      end
      if (hs_out) begin
        acc_q <= '0;
        cnt_q <= '0;
        out_cnt_q <= out_cnt_q + CNT_W'(1);
        done_q <= out_last_q;
      end
    end
endmodule

// File: tb/tb_mac_accum_requant.sv
// tb_mac_accum_requant: directed vectors for accumulate, rounding, saturation, backpressure, reset
module tb_mac_accum_requant;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic [7:0] cfg_len = '0;
  logic [7:0] cfg_num_out = '0;
  logic [4:0] cfg_shift = '0;
  logic busy, done, sat_flag;
  int vec = 0;
  int err = 0;
  int done_cnt = 0;
  logic signed [7:0] d;
  logic l;
  mac_accum_requant_if u();
  mac_accum_requant dut (.clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_num_out(cfg_num_out), .cfg_shift(cfg_shift), .s(u), .busy(busy), .done(done), .sat_flag(sat_flag));
  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [7:0] len, input logic [7:0] num, input logic [4:0] sh);
    cfg_start = 1'b1;
    cfg_len = len;
    cfg_num_out = num;
    cfg_shift = sh;
    tick();
    cfg_start = 1'b0;
  endtask
  task automatic push(input logic signed [15:0] v);
    bit ok = 1'b0;
    u.in_valid = 1'b1;
    u.in_data = v;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = u.in_ready;
      tick();
    end
    u.in_valid = 1'b0;
    if (!ok) begin
      err++;
      $display("FAIL push_timeout in_ready=0 want 1 for data %0d", v);
    end
  endtask
  task automatic pop(output logic signed [7:0] data, output logic last);
    bit ok = 1'b0;
    data = '0;
    last = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = u.out_valid;
      if (!ok) tick();
    end
    if (!ok) begin
      err++;
      $display("FAIL pop_timeout out_valid=0 want 1");
    end
    data = u.out_data;
    last = u.out_last;
    u.out_ready = 1'b1;
    tick();
    u.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    tick();
    vec++; if (u.out_valid !== 1'b0 || u.in_ready !== 1'b0) begin err++; $display("FAIL reset_stream valid=%b ready=%b want 0 0", u.out_valid, u.in_ready); end
    vec++; if (busy !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0) begin err++; $display("FAIL reset_status busy=%b done=%b sat=%b want 0 0 0", busy, done, sat_flag); end
    vec++; if (u.out_data !== 8'sd0 || u.out_last !== 1'b0) begin err++; $display("FAIL reset_data data=%0d last=%b want 0 0", u.out_data, u.out_last); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    start(8'd3, 8'd1, 5'd0);
    vec++; if (busy !== 1'b1 || u.in_ready !== 1'b1) begin err++; $display("FAIL basic_busy busy=%b ready=%b want 1 1", busy, u.in_ready); end
    push(16'sd2);
    push(16'sd6);
    push(16'sd12);
    vec++; if (u.out_valid !== 1'b0 || u.in_ready !== 1'b0) begin err++; $display("FAIL basic_round valid=%b ready=%b want 0 0", u.out_valid, u.in_ready); end
    tick();
    vec++; if (u.out_valid !== 1'b1) begin err++; $display("FAIL basic_latency out_valid=%b want 1", u.out_valid); end
    vec++; if (u.out_data !== 8'sd20 || u.out_last !== 1'b1) begin err++; $display("FAIL basic_data data=%0d last=%b want 20 1", u.out_data, u.out_last); end
    vec++; if (sat_flag !== 1'b0) begin err++; $display("FAIL basic_sat sat=%b want 0", sat_flag); end
    u.out_ready = 1'b1;
    tick();
    u.out_ready = 1'b0;
    vec++; if (done !== 1'b1 || busy !== 1'b0 || u.out_valid !== 1'b0) begin err++; $display("FAIL basic_done done=%b busy=%b valid=%b want 1 0 0", done, busy, u.out_valid); end
    tick();
    vec++; if (done !== 1'b0) begin err++; $display("FAIL basic_done_pulse done=%b want 0", done); end
  endtask
  task automatic test_rounding();
    start(8'd1, 8'd1, 5'd2);
    push(16'sd6);
    pop(d, l);
    vec++; if (d !== 8'sd2) begin err++; $display("FAIL round_pos data=%0d want 2", d); end
    start(8'd1, 8'd1, 5'd2);
    push(-16'sd6);
    pop(d, l);
    vec++; if (d !== -8'sd1) begin err++; $display("FAIL round_neg data=%0d want -1", d); end
    start(8'd1, 8'd1, 5'd2);
    push(16'sd5);
    pop(d, l);
    vec++; if (d !== 8'sd1) begin err++; $display("FAIL round_five data=%0d want 1", d); end
    start(8'd0, 8'd0, 5'd1);
    push(16'sd3);
    pop(d, l);
    vec++; if (d !== 8'sd2 || l !== 1'b1) begin err++; $display("FAIL round_zero_len data=%0d last=%b want 2 1", d, l); end
    tick();
  endtask
  task automatic test_saturation();
    start(8'd2, 8'd1, 5'd0);
    push(16'sd100);
    push(16'sd100);
    pop(d, l);
    vec++; if (d !== 8'sd127 || sat_flag !== 1'b1) begin err++; $display("FAIL sat_hi data=%0d sat=%b want 127 1", d, sat_flag); end
    tick();
    start(8'd2, 8'd1, 5'd0);
    vec++; if (sat_flag !== 1'b0) begin err++; $display("FAIL sat_clear sat=%b want 0", sat_flag); end
    push(-16'sd200);
    push(16'sd0);
    pop(d, l);
    vec++; if (d !== -8'sd128 || sat_flag !== 1'b1) begin err++; $display("FAIL sat_lo data=%0d sat=%b want -128 1", d, sat_flag); end
    tick();
  endtask
  task automatic test_back_to_back();
    int d0 = done_cnt;
    start(8'd2, 8'd2, 5'd0);
    push(16'sd1);
    push(16'sd2);
    tick();
    u.in_valid = 1'b1;
    u.in_data = 16'sd99;
    for (int i = 0; i < 3; i++) begin
      vec++; if (u.out_valid !== 1'b1 || u.out_data !== 8'sd3 || u.in_ready !== 1'b0 || u.out_last !== 1'b0) begin err++; $display("FAIL bp_hold cycle %0d valid=%b data=%0d ready=%b last=%b want 1 3 0 0", i, u.out_valid, u.out_data, u.in_ready, u.out_last); end
      tick();
    end
    u.in_valid = 1'b0;
    pop(d, l);
    vec++; if (d !== 8'sd3 || l !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL bp_first data=%0d last=%b done=%b want 3 0 0", d, l, done); end
    push(16'sd3);
    push(16'sd4);
    pop(d, l);
    vec++; if (d !== 8'sd7 || l !== 1'b1) begin err++; $display("FAIL bp_second data=%0d last=%b want 7 1", d, l); end
    tick();
    tick();
    vec++; if (done_cnt - d0 !== 1) begin err++; $display("FAIL bp_done_count got %0d want 1", done_cnt - d0); end
  endtask
  task automatic test_reset_guard();
    int d0 = done_cnt;
    start(8'd3, 8'd1, 5'd0);
    push(16'sd5);
    rst = 1'b1;
    #1;
    vec++; if (busy !== 1'b0 || u.in_ready !== 1'b0 || u.out_valid !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0 || u.out_data !== 8'sd0) begin err++; $display("FAIL rst_mid busy=%b ready=%b valid=%b done=%b sat=%b data=%0d want all 0", busy, u.in_ready, u.out_valid, done, sat_flag, u.out_data); end
    tick();
    rst = 1'b0;
    tick();
    vec++; if (done_cnt !== d0 || busy !== 1'b0) begin err++; $display("FAIL rst_no_done done_pulses=%0d busy=%b want %0d 0", done_cnt, busy, d0); end
    start(8'd3, 8'd1, 5'd0);
    push(16'sd4);
    cfg_start = 1'b1;
    cfg_len = 8'd1;
    cfg_shift = 5'd3;
    tick();
    cfg_start = 1'b0;
    push(16'sd4);
    vec++; if (u.in_ready !== 1'b1) begin err++; $display("FAIL guard_len ready=%b want 1", u.in_ready); end
    push(16'sd4);
    pop(d, l);
    vec++; if (d !== 8'sd12 || l !== 1'b1) begin err++; $display("FAIL guard_data data=%0d last=%b want 12 1", d, l); end
    tick();
  endtask
  initial begin
    u.in_valid = 1'b0;
    u.in_data = '0;
    u.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_guard();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
